// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED fade sequencer and its PWM datapath.
package led_seq_pkg;

  localparam int LVL_W = 3;
  localparam int VAL_W = 4;
  localparam int LVL_MAX = 4;

  localparam logic [LVL_W-1:0] LVL_TOP  = 3'd4;
  localparam logic [LVL_W-1:0] LVL_ZERO = 3'd0;
  localparam logic [LVL_W-1:0] LVL_ONE  = 3'd1;
  localparam logic [VAL_W-1:0] VAL_TOP  = 4'hF;
  localparam logic [VAL_W-1:0] VAL_ZERO = 4'h0;
  localparam logic [VAL_W-1:0] VAL_ONE  = 4'h1;

  typedef enum logic [1:0] {
    MANUAL  = 2'd0,
    AUTO_UP = 2'd1,
    AUTO_DN = 2'd2
  } seq_state_e;

  // Binary to reflected Gray code.
  function automatic logic [VAL_W-1:0] gray_of(input logic [VAL_W-1:0] v);
    return v ^ (v >> 1'b1);
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// PWM frame counter, frame-aligned duty/pattern latch and registered LED gate.
module led_pwm_gen
  import led_seq_pkg::*;
#(
  parameter int PWM_PERIOD = 1_000_000,
  parameter int MIN_DUTY   = 50_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LVL_W-1:0] level_i,
  input  logic [VAL_W-1:0] value_i,
  output logic [VAL_W-1:0] usr_led_o,
  output logic             frame_end_o
);

  localparam int CW = $clog2(PWM_PERIOD + 1);
  // Product is formed LVL_W bits wider than the counter so level*PERIOD can never wrap.
  localparam int PW = CW + LVL_W;
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] DUTY_MIN = CW'(MIN_DUTY);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    duty_q, duty_next_s;
  logic [VAL_W-1:0] gray_q;
  logic [VAL_W-1:0] led_q;
  logic             frame_end_q;

  // Next counter value: free-running, wrapping at the end of each frame.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Duty for the next frame: a dim floor at level 0, quarter steps above it.
  always_comb begin
    duty_next_s = DUTY_MIN;
    if (level_i == LVL_ZERO) begin
      duty_next_s = DUTY_MIN;
    end else begin
      duty_next_s = CW'((PW'(level_i) * PW'(PWM_PERIOD)) / PW'(3'd4));
    end
  end

  // Counter, frame marker, frame-boundary latches and the gated LED register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= CNT_ZERO;
      frame_end_q <= 1'b0;
      duty_q      <= DUTY_MIN;
      gray_q      <= VAL_ZERO;
      led_q       <= VAL_ZERO;
    end else begin
      cnt_q       <= cnt_d;
      frame_end_q <= (cnt_d == CNT_LAST);
      if (frame_end_q) begin
        duty_q <= duty_next_s;
        gray_q <= gray_of(value_i);
      end
      led_q <= (cnt_q < duty_q) ? gray_q : VAL_ZERO;
    end
  end

  assign usr_led_o   = led_q;
  assign frame_end_o = frame_end_q;

endmodule

// File: rtl/led_fade_sequencer.sv
// Button-driven display/brightness controller with manual and automatic fade modes.
module led_fade_sequencer
  import led_seq_pkg::*;
#(
  parameter int PWM_PERIOD   = 1_000_000,
  parameter int MIN_DUTY     = 50_000,
  parameter int FADE_PERIODS = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             val_dn,
  input  logic             val_up,
  input  logic             lvl_up,
  input  logic             lvl_dn,
  input  logic             mode_tgl,
  output logic [VAL_W-1:0] usr_led,
  output logic [VAL_W-1:0] value,
  output logic [LVL_W-1:0] level,
  output logic             auto_mode,
  output logic             frame_end
);

  localparam int FW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  localparam logic [FW-1:0] FADE_LAST = FW'(FADE_PERIODS - 1);
  localparam logic [FW-1:0] FADE_ZERO = FW'(1'b0);
  localparam logic [FW-1:0] FADE_ONE  = FW'(1'b1);

  seq_state_e       state_q, state_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [FW-1:0]    fade_q, fade_d;
  logic             frame_end_s;

  led_pwm_gen #(
    .PWM_PERIOD(PWM_PERIOD),
    .MIN_DUTY  (MIN_DUTY)
  ) u_pwm (
    .clk        (clk),
    .reset      (reset),
    .level_i    (level_q),
    .value_i    (value_q),
    .usr_led_o  (usr_led),
    .frame_end_o(frame_end_s)
  );

  // Sequencer next state: manual edits, mode toggles and frame-paced fade steps.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    level_d = level_q;
    fade_d  = fade_q;
    case (state_q)
      MANUAL: begin
        if (mode_tgl) begin
          state_d = (level_q == LVL_TOP) ? AUTO_DN : AUTO_UP;
          fade_d  = FADE_ZERO;
        end else begin
          if (val_up && !val_dn && (value_q != VAL_TOP)) begin
            value_d = value_q + VAL_ONE;
          end else if (val_dn && !val_up && (value_q != VAL_ZERO)) begin
            value_d = value_q - VAL_ONE;
          end else begin
            value_d = value_q;
          end
          if (lvl_up && !lvl_dn && (level_q != LVL_TOP)) begin
            level_d = level_q + LVL_ONE;
          end else if (lvl_dn && !lvl_up && (level_q != LVL_ZERO)) begin
            level_d = level_q - LVL_ONE;
          end else begin
            level_d = level_q;
          end
        end
      end
      AUTO_UP, AUTO_DN: begin
        if (mode_tgl) begin
          // Toggle beats any fade step landing on the same cycle.
          state_d = MANUAL;
          fade_d  = FADE_ZERO;
        end else if (frame_end_s) begin
          if (fade_q == FADE_LAST) begin
            fade_d = FADE_ZERO;
            if (state_q == AUTO_UP) begin
              level_d = level_q + LVL_ONE;
              state_d = ((level_q + LVL_ONE) == LVL_TOP) ? AUTO_DN : AUTO_UP;
            end else begin
              level_d = level_q - LVL_ONE;
              if (level_q == LVL_ONE) begin
                state_d = AUTO_UP;
                value_d = value_q + VAL_ONE;
              end else begin
                state_d = AUTO_DN;
              end
            end
          end else begin
            fade_d = fade_q + FADE_ONE;
          end
        end else begin
          fade_d = fade_q;
        end
      end
      default: begin
        state_d = MANUAL;
        fade_d  = FADE_ZERO;
      end
    endcase
  end

  // Sequencer state, display value, brightness level and fade frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MANUAL;
      value_q <= VAL_ZERO;
      level_q <= LVL_ZERO;
      fade_q  <= FADE_ZERO;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      level_q <= level_d;
      fade_q  <= fade_d;
    end
  end

  assign value     = value_q;
  assign level     = level_q;
  assign auto_mode = (state_q != MANUAL);
  assign frame_end = frame_end_s;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Self-checking bench: per-cycle reference model with an LED scoreboard queue,
// a table of manual-mode vectors, and hand sequences for fade/timing corners.
module tb_led_fade_sequencer;

  localparam int P  = 8;
  localparam int MD = 1;
  localparam int FP = 2;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] VU   = 5'b00001;
  localparam logic [4:0] VD   = 5'b00010;
  localparam logic [4:0] LU   = 5'b00100;
  localparam logic [4:0] LD   = 5'b01000;
  localparam logic [4:0] TG   = 5'b10000;

  logic       clk = 1'b0;
  logic       reset, val_dn, val_up, lvl_up, lvl_dn, mode_tgl;
  logic [3:0] usr_led, value;
  logic [2:0] level;
  logic       auto_mode, frame_end;

  always #5 clk = ~clk;

  led_fade_sequencer #(
    .PWM_PERIOD  (P),
    .MIN_DUTY    (MD),
    .FADE_PERIODS(FP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .val_dn   (val_dn),
    .val_up   (val_up),
    .lvl_up   (lvl_up),
    .lvl_dn   (lvl_dn),
    .mode_tgl (mode_tgl),
    .usr_led  (usr_led),
    .value    (value),
    .level    (level),
    .auto_mode(auto_mode),
    .frame_end(frame_end)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected usr_led values, one per clock edge.
  int exp_q[$];

  // Reference model (st: 0 manual, 1 fading up, 2 fading down).
  int m_ph, m_duty, m_gray, m_val, m_lvl, m_st, m_fade;

  typedef struct {
    logic [4:0] p;
    int         ev;
    int         el;
    int         ea;
  } vec_t;
  vec_t tbl[$];

  function automatic int gray4(input int v);
    return (v ^ (v >> 1)) & 15;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic add(input logic [4:0] p, input int ev, input int el, input int ea);
    vec_t v;
    v.p = p; v.ev = ev; v.el = el; v.ea = ea;
    tbl.push_back(v);
  endtask

  // One clock: drive pulses, advance the model, then compare after the edge.
  task automatic tick(input logic rst, input logic [4:0] p);
    bit fe;
    {mode_tgl, lvl_dn, lvl_up, val_dn, val_up} = p;
    reset = rst;
    if (rst) begin
      exp_q.push_back(0);
      m_ph = 0; m_duty = MD; m_gray = 0; m_val = 0; m_lvl = 0; m_st = 0; m_fade = 0;
    end else begin
      exp_q.push_back((m_ph < m_duty) ? m_gray : 0);
      fe = (m_ph == P - 1);
      if (fe) begin
        m_duty = (m_lvl == 0) ? MD : (m_lvl * P) / 4;
        m_gray = gray4(m_val);
      end
      if (m_st == 0) begin
        if (p[4]) begin
          m_st = (m_lvl == 4) ? 2 : 1;
          m_fade = 0;
        end else begin
          if (p[0] && !p[1] && m_val < 15) m_val++;
          else if (p[1] && !p[0] && m_val > 0) m_val--;
          if (p[2] && !p[3] && m_lvl < 4) m_lvl++;
          else if (p[3] && !p[2] && m_lvl > 0) m_lvl--;
        end
      end else if (p[4]) begin
        m_st = 0;
        m_fade = 0;
      end else if (fe) begin
        if (m_fade == FP - 1) begin
          m_fade = 0;
          if (m_st == 1) begin
            m_lvl++;
            if (m_lvl == 4) m_st = 2;
          end else begin
            m_lvl--;
            if (m_lvl == 0) begin
              m_st = 1;
              m_val = (m_val + 1) % 16;
            end
          end
        end else begin
          m_fade++;
        end
      end
      m_ph = (m_ph + 1) % P;
    end
    @(posedge clk);
    #1;
    {mode_tgl, lvl_dn, lvl_up, val_dn, val_up} = NONE;
    reset = 1'b0;
    check("usr_led", int'(usr_led), exp_q.pop_front());
    check("frame_end", int'(frame_end), (m_ph == P - 1) ? 1 : 0);
    check("value", int'(value), m_val);
    check("level", int'(level), m_lvl);
    check("auto_mode", int'(auto_mode), (m_st != 0) ? 1 : 0);
  endtask

  task automatic wait_frame_end();
    for (int i = 0; i < 2 * P && !frame_end; i++) tick(1'b0, NONE);
    check("frame_end_wait", int'(frame_end), 1);
  endtask

  initial begin : main
    int n_a;
    int prev, steps;
    int seen[$];
    int when[$];
    int exp_seq[8];
    int fe_cnt;
    logic [13:0] obs;

    // Manual-mode vectors: {pulses, value, level, auto} after the pulse.
    add(VD, 0, 0, 0);        // value floor
    add(LD, 0, 0, 0);        // level floor
    add(VU, 1, 0, 0);
    add(VU, 2, 0, 0);
    add(VU, 3, 0, 0);
    add(LU, 3, 1, 0);
    add(LU, 3, 2, 0);
    add(VU | VD, 3, 2, 0);   // simultaneous -> no change
    add(LU | LD, 3, 2, 0);
    n_a = tbl.size();
    for (int v = 4; v <= 15; v++) add(VU, v, 2, 0);
    add(VU, 15, 2, 0);       // value ceiling
    add(LU, 15, 3, 0);
    add(LU, 15, 4, 0);
    add(LU, 15, 4, 0);       // level ceiling
    for (int l = 3; l >= 0; l--) add(LD, 15, l, 0);
    add(LD, 15, 0, 0);
    add(TG | VU, 15, 0, 1);  // toggle swallows the coincident pulse
    exp_seq = '{1, 2, 3, 4, 3, 2, 1, 0};

    reset = 1'b1;
    {mode_tgl, lvl_dn, lvl_up, val_dn, val_up} = NONE;
    tick(1'b1, NONE);
    tick(1'b1, NONE);
    check("rst_led", int'(usr_led), 0);
    check("rst_frame_end", int'(frame_end), 0);
    for (int i = 0; i < 16; i++) tick(1'b0, NONE);
    check("idle_level", int'(level), 0);
    check("idle_auto", int'(auto_mode), 0);

    for (int i = 0; i < n_a; i++) begin
      tick(1'b0, tbl[i].p);
      check("vec_value", int'(value), tbl[i].ev);
      check("vec_level", int'(level), tbl[i].el);
      check("vec_auto", int'(auto_mode), tbl[i].ea);
    end

    // value 3 / level 2: gray 0010 lit for the first half of the next frame.
    wait_frame_end();
    tick(1'b0, NONE);
    for (int k = 0; k < P; k++) begin
      tick(1'b0, NONE);
      check("frame_led", int'(usr_led), (k < 4) ? 2 : 0);
    end

    for (int i = n_a; i < tbl.size(); i++) begin
      tick(1'b0, tbl[i].p);
      check("vec_value", int'(value), tbl[i].ev);
      check("vec_level", int'(level), tbl[i].el);
      check("vec_auto", int'(auto_mode), tbl[i].ea);
    end

    // Auto fade: pulses ignored, then the full up/down sweep with value wrap.
    tick(1'b0, NONE);
    tick(1'b0, VU);
    check("auto_ign_val", int'(value), 15);
    tick(1'b0, LU);
    check("auto_ign_lvl", int'(level), 0);
    prev = level;
    steps = 0;
    for (int c = 0; c < 200 && seen.size() < 8; c++) begin
      tick(1'b0, NONE);
      steps++;
      if (int'(level) != prev) begin
        seen.push_back(int'(level));
        when.push_back(steps);
        prev = level;
      end
    end
    check("auto_steps", seen.size(), 8);
    for (int i = 0; i < seen.size() && i < 8; i++) begin
      check("auto_lvl", seen[i], exp_seq[i]);
      if (i > 0) check("auto_gap", when[i] - when[i-1], 2 * P);
    end
    check("auto_wrap_val", int'(value), 0);
    check("auto_still", int'(auto_mode), 1);

    // Leave auto at level 2 and confirm the freeze.
    for (int i = 0; i < 64 && level != 3'd2; i++) tick(1'b0, NONE);
    check("reach_lvl2", int'(level), 2);
    tick(1'b0, TG);
    check("frz_auto", int'(auto_mode), 0);
    check("frz_lvl", int'(level), 2);
    for (int i = 0; i < 40; i++) tick(1'b0, NONE);
    check("frz_lvl_hold", int'(level), 2);
    check("frz_val_hold", int'(value), 0);
    tick(1'b0, VU);
    check("manual_again", int'(value), 1);
    tick(1'b0, TG);
    check("reauto", int'(auto_mode), 1);
    for (int i = 0; i < 10; i++) tick(1'b0, NONE);

    // Reset in the middle of auto mode.
    tick(1'b1, NONE);
    check("mid_rst_val", int'(value), 0);
    check("mid_rst_lvl", int'(level), 0);
    check("mid_rst_auto", int'(auto_mode), 0);
    check("mid_rst_led", int'(usr_led), 0);
    check("mid_rst_fe", int'(frame_end), 0);
    fe_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, NONE);
      if (frame_end) fe_cnt++;
    end
    check("fe_per_16", fe_cnt, 2);

    // Level change at pwm_cnt 2 must not alter the running frame.
    tick(1'b0, VU);
    wait_frame_end();
    tick(1'b0, NONE);
    tick(1'b0, NONE);
    tick(1'b0, NONE);
    tick(1'b0, LU);
    obs[0] = (usr_led != 4'd0);
    for (int k = 1; k < 14; k++) begin
      tick(1'b0, NONE);
      obs[k] = (usr_led != 4'd0);
    end
    check("midframe_pattern", int'(obs), 14'h00C0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
